// File: rtl/sys1_prgrom_arb_if.sv
// Program-ROM arbiter bus: CPU and aux requesters plus the shared ROM/decryptor port.
// The slave modport is the arbiter side; the master modport is the requester/ROM side.
interface sys1_prgrom_arb_if;
  logic        cpu_req;
  logic        cpu_m1;
  logic [14:0] cpu_ad;
  logic [7:0]  cpu_dt;
  logic        cpu_ack;
  logic        aux_req;
  logic [14:0] aux_ad;
  logic [7:0]  aux_dt;
  logic        aux_ack;
  logic        rom_m1;
  logic [14:0] rom_ad;
  logic [7:0]  rom_raw;
  logic [7:0]  rom_dec;

  modport slave (
    input  cpu_req, cpu_m1, cpu_ad, aux_req, aux_ad, rom_raw, rom_dec,
    output cpu_dt, cpu_ack, aux_dt, aux_ack, rom_m1, rom_ad
  );

  modport master (
    output cpu_req, cpu_m1, cpu_ad, aux_req, aux_ad, rom_raw, rom_dec,
    input  cpu_dt, cpu_ack, aux_dt, aux_ack, rom_m1, rom_ad
  );
endinterface

// File: rtl/sys1_prgrom_arb.sv
// Shares one program ROM/decryptor between CPU (decrypted) and aux (raw) readers.
// Define SYS1_PRGARB_RR_EN for round-robin arbitration; default is fixed CPU priority.
module sys1_prgrom_arb #(
  parameter int unsigned ROM_LAT = 2
) (
  input logic             i_clk,
  input logic             i_rst,
  sys1_prgrom_arb_if.slave io_bus
);

  typedef enum logic [1:0] {StIdle, StCpuRd, StAuxRd} state_e;

  localparam logic [2:0] LatInit = 3'(ROM_LAT);

  state_e      r_state, w_state_nxt;
  logic [2:0]  r_cnt, w_cnt_nxt;
  logic [14:0] r_rom_ad, w_rom_ad_nxt;
  logic        r_m1, w_m1_nxt;
  logic [7:0]  r_cpu_dt, w_cpu_dt_nxt;
  logic [7:0]  r_aux_dt, w_aux_dt_nxt;
  logic        w_gnt_cpu;
  logic        w_gnt_aux;
  logic        w_cpu_ack;
  logic        w_aux_ack;

`ifdef SYS1_PRGARB_RR_EN
  logic r_last_cpu, w_last_cpu_nxt;

  // On a tie the requester that did not win last time gets the ROM.
  assign w_gnt_cpu = io_bus.cpu_req && !(io_bus.aux_req && r_last_cpu);
`else
  assign w_gnt_cpu = io_bus.cpu_req;
`endif
  assign w_gnt_aux = io_bus.aux_req && !w_gnt_cpu;

  // Ack is the single cycle in which the grant's counter sits at zero.
  assign w_cpu_ack = (r_state == StCpuRd) && (r_cnt == 3'd0);
  assign w_aux_ack = (r_state == StAuxRd) && (r_cnt == 3'd0);

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_rom_ad_nxt = r_rom_ad;
    w_m1_nxt     = r_m1;
    w_cpu_dt_nxt = r_cpu_dt;
    w_aux_dt_nxt = r_aux_dt;
`ifdef SYS1_PRGARB_RR_EN
    w_last_cpu_nxt = r_last_cpu;
`endif
    unique case (r_state)
      StIdle: begin
        if (w_gnt_cpu) begin
          w_state_nxt  = StCpuRd;
          w_cnt_nxt    = LatInit;
          w_rom_ad_nxt = io_bus.cpu_ad;
          w_m1_nxt     = io_bus.cpu_m1;
`ifdef SYS1_PRGARB_RR_EN
          w_last_cpu_nxt = 1'b1;
`endif
        end else if (w_gnt_aux) begin
          w_state_nxt  = StAuxRd;
          w_cnt_nxt    = LatInit;
          w_rom_ad_nxt = io_bus.aux_ad;
          w_m1_nxt     = 1'b0;
`ifdef SYS1_PRGARB_RR_EN
          w_last_cpu_nxt = 1'b0;
`endif
        end
      end
      StCpuRd: begin
        if (r_cnt == 3'd0) begin
          w_state_nxt = StIdle;
        end else begin
          w_cnt_nxt = r_cnt - 3'd1;
          if (r_cnt == 3'd1) w_cpu_dt_nxt = io_bus.rom_dec;
        end
      end
      StAuxRd: begin
        if (r_cnt == 3'd0) begin
          w_state_nxt = StIdle;
        end else begin
          w_cnt_nxt = r_cnt - 3'd1;
          if (r_cnt == 3'd1) w_aux_dt_nxt = io_bus.rom_raw;
        end
      end
      default: begin
        w_state_nxt = StIdle;
        w_cnt_nxt   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= StIdle;
      r_cnt    <= 3'd0;
      r_rom_ad <= 15'd0;
      r_m1     <= 1'b0;
      r_cpu_dt <= 8'd0;
      r_aux_dt <= 8'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_rom_ad <= w_rom_ad_nxt;
      r_m1     <= w_m1_nxt;
      r_cpu_dt <= w_cpu_dt_nxt;
      r_aux_dt <= w_aux_dt_nxt;
    end
  end

`ifdef SYS1_PRGARB_RR_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_last_cpu <= 1'b0;
    else       r_last_cpu <= w_last_cpu_nxt;
  end
`endif

  assign io_bus.cpu_dt  = r_cpu_dt;
  assign io_bus.aux_dt  = r_aux_dt;
  assign io_bus.cpu_ack = w_cpu_ack;
  assign io_bus.aux_ack = w_aux_ack;
  assign io_bus.rom_ad  = r_rom_ad;
  assign io_bus.rom_m1  = (r_state == StCpuRd) && r_m1;

  a_one_ack: assert property (@(posedge i_clk) disable iff (i_rst) !(w_cpu_ack && w_aux_ack));
  a_ad_stable: assert property (@(posedge i_clk) disable iff (i_rst)
    (r_state != StIdle) |=> ((r_state == StIdle) || $stable(r_rom_ad)));

endmodule

// File: tb/tb_sys1_prgrom_arb.sv
// Self-checking bench for sys1_prgrom_arb: directed table, corner sequences, random vs model.
module tb_sys1_prgrom_arb;
  localparam int unsigned LAT = 2;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_bad = 0;

  sys1_prgrom_arb_if bus ();

  sys1_prgrom_arb #(.ROM_LAT(LAT)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .io_bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic        cr;
    logic        m1;
    logic [14:0] ca;
    logic        ar;
    logic [14:0] aa;
    logic [7:0]  raw;
    logic [7:0]  dec;
    logic [33:0] exp;
  } vec_t;

  function automatic logic [33:0] ex(input logic ca_k, input logic aa_k, input logic m1,
                                     input logic [7:0] cdt, input logic [7:0] adt,
                                     input logic [14:0] ad);
    return {ca_k, aa_k, m1, cdt, adt, ad};
  endfunction

  function automatic logic [33:0] obs();
    return {bus.cpu_ack, bus.aux_ack, bus.rom_m1, bus.cpu_dt, bus.aux_dt, bus.rom_ad};
  endfunction

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic cr, input logic m1, input logic [14:0] ca, input logic ar,
                       input logic [14:0] aa, input logic [7:0] raw, input logic [7:0] dec);
    bus.cpu_req = cr;
    bus.cpu_m1  = m1;
    bus.cpu_ad  = ca;
    bus.aux_req = ar;
    bus.aux_ad  = aa;
    bus.rom_raw = raw;
    bus.rom_dec = dec;
  endtask

  // Reset across one full clock, released at a negedge.
  task automatic do_reset();
    drive(0, 0, 15'd0, 0, 15'd0, 8'd0, 8'd0);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Reference model: timeline of grants measured in clock edges.
  int          m_e, m_free, m_gnt, m_kind;
  logic [14:0] m_ad;
  logic        m_m1, m_last_cpu;
  logic [7:0]  m_cdt, m_adt;

  task automatic model_init();
    m_e = 0; m_free = 0; m_gnt = -100; m_kind = 0;
    m_ad = '0; m_m1 = 0; m_last_cpu = 0; m_cdt = '0; m_adt = '0;
  endtask

  task automatic model_edge(output logic [33:0] exp);
    logic ack_c, ack_a, m1e, pick_cpu;
    ack_c = 0;
    ack_a = 0;
    if (m_e >= m_free && (bus.cpu_req || bus.aux_req)) begin
`ifdef SYS1_PRGARB_RR_EN
      pick_cpu = bus.cpu_req && !(bus.aux_req && m_last_cpu);
`else
      pick_cpu = bus.cpu_req;
`endif
      m_kind     = pick_cpu ? 1 : 2;
      m_gnt      = m_e;
      m_free     = m_e + int'(LAT) + 2;
      m_ad       = pick_cpu ? bus.cpu_ad : bus.aux_ad;
      m_m1       = pick_cpu ? bus.cpu_m1 : 1'b0;
      m_last_cpu = pick_cpu;
    end
    if (m_kind != 0 && m_e == m_gnt + int'(LAT)) begin
      if (m_kind == 1) begin ack_c = 1; m_cdt = bus.rom_dec; end
      else             begin ack_a = 1; m_adt = bus.rom_raw; end
    end
    m1e = (m_kind == 1 && m_e >= m_gnt && m_e <= m_gnt + int'(LAT)) ? m_m1 : 1'b0;
    exp = {ack_c, ack_a, m1e, m_cdt, m_adt, m_ad};
    m_e++;
  endtask

  vec_t        tbl[15];
  logic [1:0]  seq_exp[4];
  logic [1:0]  seq_got[4];
  int          seq_cyc[4];

  initial begin
    logic [33:0] e;
    logic        cr, ar;
    int          k, n;

    tbl[0]  = '{1, 1, 15'h1234, 0, 15'h0000, 8'h00, 8'h11, ex(0, 0, 1, 8'h00, 8'h00, 15'h1234)};
    tbl[1]  = '{1, 1, 15'h0000, 0, 15'h0000, 8'h00, 8'h22, ex(0, 0, 1, 8'h00, 8'h00, 15'h1234)};
    tbl[2]  = '{1, 0, 15'h0000, 0, 15'h0000, 8'h00, 8'h33, ex(1, 0, 1, 8'h33, 8'h00, 15'h1234)};
    tbl[3]  = '{0, 0, 15'h0000, 0, 15'h0000, 8'h00, 8'h44, ex(0, 0, 0, 8'h33, 8'h00, 15'h1234)};
    tbl[4]  = '{0, 0, 15'h0000, 1, 15'h7FFF, 8'hA5, 8'h5A, ex(0, 0, 0, 8'h33, 8'h00, 15'h7FFF)};
    tbl[5]  = '{0, 0, 15'h0000, 1, 15'h0001, 8'hA5, 8'h5A, ex(0, 0, 0, 8'h33, 8'h00, 15'h7FFF)};
    tbl[6]  = '{0, 0, 15'h0000, 1, 15'h0001, 8'hA5, 8'h5A, ex(0, 1, 0, 8'h33, 8'hA5, 15'h7FFF)};
    tbl[7]  = '{0, 0, 15'h0000, 0, 15'h0000, 8'h00, 8'h00, ex(0, 0, 0, 8'h33, 8'hA5, 15'h7FFF)};
    tbl[8]  = '{1, 1, 15'h0002, 1, 15'h0003, 8'h66, 8'h77, ex(0, 0, 1, 8'h33, 8'hA5, 15'h0002)};
    tbl[9]  = '{0, 0, 15'h0004, 1, 15'h0003, 8'h66, 8'h77, ex(0, 0, 1, 8'h33, 8'hA5, 15'h0002)};
    tbl[10] = '{0, 0, 15'h0004, 1, 15'h0003, 8'h66, 8'h88, ex(1, 0, 1, 8'h88, 8'hA5, 15'h0002)};
    tbl[11] = '{0, 0, 15'h0004, 1, 15'h0003, 8'h66, 8'h88, ex(0, 0, 0, 8'h88, 8'hA5, 15'h0002)};
    tbl[12] = '{0, 0, 15'h0004, 1, 15'h0005, 8'h99, 8'h88, ex(0, 0, 0, 8'h88, 8'hA5, 15'h0005)};
    tbl[13] = '{0, 0, 15'h0004, 0, 15'h0006, 8'h99, 8'h88, ex(0, 0, 0, 8'h88, 8'hA5, 15'h0005)};
    tbl[14] = '{0, 0, 15'h0004, 0, 15'h0006, 8'hBB, 8'h88, ex(0, 1, 0, 8'h88, 8'hBB, 15'h0005)};

    // Reset state
    drive(0, 0, 15'd0, 0, 15'd0, 8'd0, 8'd0);
    rst = 1'b1;
    @(negedge clk);
    cmp("reset_state", 64'(obs()), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].cr, tbl[i].m1, tbl[i].ca, tbl[i].ar, tbl[i].aa, tbl[i].raw, tbl[i].dec);
      @(negedge clk);
      cmp($sformatf("table_row%0d", i), 64'(obs()), 64'(tbl[i].exp));
    end

    // Both requesters held for four grants
    do_reset();
`ifdef SYS1_PRGARB_RR_EN
    seq_exp = '{2'd1, 2'd2, 2'd1, 2'd2};
`else
    seq_exp = '{2'd1, 2'd1, 2'd1, 2'd1};
`endif
    seq_got = '{2'd0, 2'd0, 2'd0, 2'd0};
    seq_cyc = '{0, 0, 0, 0};
    drive(1, 1, 15'h0111, 1, 15'h0222, 8'h3C, 8'hC3);
    n = 0;
    for (int c = 1; c <= 40 && n < 4; c++) begin
      @(negedge clk);
      if (bus.cpu_ack || bus.aux_ack) begin
        seq_got[n] = {bus.aux_ack, bus.cpu_ack};
        seq_cyc[n] = c;
        n++;
      end
    end
    for (int i = 0; i < 4; i++) cmp($sformatf("arb_order%0d", i), 64'(seq_got[i]),
                                    64'(seq_exp[i]));
    cmp("first_ack_latency", 64'(seq_cyc[0]), 64'(LAT + 1));
    for (int i = 1; i < 4; i++) cmp($sformatf("ack_spacing%0d", i),
                                    64'(seq_cyc[i] - seq_cyc[i-1]), 64'(LAT + 2));

    // Reset in the middle of a CPU grant
    do_reset();
    drive(1, 1, 15'h0ABC, 0, 15'd0, 8'h12, 8'h34);
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    #1 cmp("reset_async_clear", 64'(obs()), 64'd0);
    @(negedge clk);
    cmp("reset_held_no_ack", 64'(obs()), 64'd0);
    rst = 1'b0;
    k = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) cmp("regrant_rom_ad", 64'(bus.rom_ad), 64'h0ABC);
      if (bus.cpu_ack) begin
        k = c;
        break;
      end
    end
    cmp("regrant_ack_latency", 64'(k), 64'(LAT + 1));
    cmp("regrant_cpu_dt", 64'(bus.cpu_dt), 64'h34);

    // Randomized traffic against the timeline model
    do_reset();
    model_init();
    cr = 0;
    ar = 0;
    for (int i = 0; i < 3000; i++) begin
      if (cr) begin
        if (bus.cpu_ack) cr = 1'($urandom_range(0, 1));
        else if ($urandom_range(0, 15) == 0) cr = 0;
      end else cr = ($urandom_range(0, 2) == 0);
      if (ar) begin
        if (bus.aux_ack) ar = 1'($urandom_range(0, 1));
        else if ($urandom_range(0, 15) == 0) ar = 0;
      end else ar = ($urandom_range(0, 2) == 0);
      drive(cr, 1'($urandom), 15'($urandom), ar, 15'($urandom), 8'($urandom), 8'($urandom));
      model_edge(e);
      @(negedge clk);
      cmp("random", 64'(obs()), 64'(e));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sys1_prgrom_arb.md
SYS1_PRGROM_ARB -- requirements
Module: sys1_prgrom_arb

Interface
REQ-001 ROM_LAT, 2, number of clk cycles from ROM address launch to valid data on rom_raw/rom_dec; legal range 1..7.
REQ-002 clk  input  1  system clock; all state on posedge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 cpu_req  input  1  CPU read request; level, held until cpu_ack.
REQ-005 cpu_m1  input  1  CPU opcode-fetch qualifier, forwarded to the decryptor.
REQ-006 cpu_ad  input  15  CPU program ROM address.
REQ-007 cpu_dt  output  8  decrypted read data; valid in the cpu_ack cycle.
REQ-008 cpu_ack  output  1  one-cycle completion pulse for CPU.
REQ-009 aux_req  input  1  auxiliary (checksum/debug) read request; level, held until aux_ack.
REQ-010 aux_ad  input  15  auxiliary ROM address.
REQ-011 aux_dt  output  8  raw (undecrypted) read data; valid in the aux_ack cycle.
REQ-012 aux_ack  output  1  one-cycle completion pulse for aux.
REQ-013 rom_m1  output  1  M1 qualifier to decryptor; 0 for aux grants.
REQ-014 rom_ad  output  15  address to decryptor/ROM; held stable for the whole grant.
REQ-015 rom_raw  input  8  raw ROM data.
REQ-016 rom_dec  input  8  decryptor output data.

Function
REQ-017 FSM states: IDLE, CPU_RD, AUX_RD.
REQ-018 IDLE with any request pending -> grant on next edge; rom_ad/rom_m1 latched from the granted requester at that same edge.
REQ-019 Default arbitration fixed priority: cpu_req beats aux_req when both sampled high in the same IDLE cycle.
REQ-020 Grant starts a 3-bit down-counter loaded with ROM_LAT; decrements once per cycle in CPU_RD/AUX_RD.
REQ-021 Counter reaching 0 -> that cycle asserts the matching ack for exactly one cycle, drives cpu_dt from rom_dec (CPU) or aux_dt from rom_raw (aux), and FSM returns to IDLE on the next edge.
REQ-022 Latency: request first sampled in IDLE at edge N -> ack high in cycle N+1+ROM_LAT; minimum spacing between consecutive grants is ROM_LAT+2 cycles.
REQ-023 cpu_dt/aux_dt registered; hold last delivered value between acks.
REQ-024 Request deassertion during a grant does not abort; access completes and ack still pulses.
REQ-025 Request inputs are ignored outside IDLE; address inputs are ignored after the latching edge.
REQ-026 Never more than one ack high in any cycle; never ack without a prior grant.
REQ-027 rom_m1 = latched cpu_m1 in CPU_RD, 0 in AUX_RD, 0 in IDLE.

Reset
REQ-028 Reset asserted: state IDLE, counter 0, cpu_ack=aux_ack=0, cpu_dt=aux_dt=0, rom_ad=0, rom_m1=0, fairness flag=0, immediately (asynchronous).
REQ-029 Reset mid-grant aborts the access with no ack; first grant possible on the first edge after reset deasserts.

Configuration
REQ-030 Macro SYS1_PRGARB_RR_EN defined: round-robin; one-bit last-grant flag, on simultaneous requests the requester not granted last wins; flag updates at each grant.
REQ-031 SYS1_PRGARB_RR_EN undefined: fixed CPU priority per REQ-019; no fairness flag logic.

Verification
REQ-032 ROM_LAT=2, cpu_req=1, cpu_ad=15'h1234, cpu_m1=1 at edge 0 -> rom_ad=15'h1234, rom_m1=1 from cycle 1; cpu_ack=1 in cycle 3 only, cpu_dt=rom_dec value.
REQ-033 aux_req=1, aux_ad=15'h7FFF, rom_raw=8'hA5, rom_dec=8'h5A -> aux_ack one cycle, aux_dt=8'hA5, rom_m1=0 throughout.
REQ-034 cpu_req and aux_req both held high for 4 grants -> without macro: CPU,CPU,CPU,CPU; with SYS1_PRGARB_RR_EN: CPU,AUX,CPU,AUX.
REQ-035 reset pulsed in cycle 2 of a CPU grant -> no cpu_ack, all outputs 0; after release with cpu_req high, new grant on first edge and ack ROM_LAT+1 cycles later.
REQ-036 cpu_req dropped one cycle after grant -> cpu_ack still pulses at N+1+ROM_LAT; back-to-back held req gives acks exactly ROM_LAT+2 cycles apart.
